// File: rtl/cp0.sv
// Coprocessor-0 exception/interrupt controller beside the M stage: SR/Cause/EPC/PRId, handler entry and eret.
// Optional macro CP0_BD_EN enables Cause.BD and the delay-slot EPC adjustment (pc-4).
module cp0 #(
  parameter logic [31:0] PRID_VAL = 32'h0019_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [31:0] pc,
  input  logic        bd,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic [31:0] dout,
  output logic [31:0] epc_out,
  output logic        int_req
);

  // SR.EXL is the state bit: USER runs code, HANDLER masks all new requests.
  typedef enum logic {USER = 1'b0, HANDLER = 1'b1} state_t;

  state_t      state_r, state_n_s;
  logic [5:0]  im_r, im_n_s;
  logic        ie_r, ie_n_s;
  logic [5:0]  ip_r;
  logic [4:0]  exc_code_r, exc_code_n_s;
  logic        bd_r, bd_n_s;
  logic [31:0] epc_r, epc_n_s;

  logic        exl_s;
  logic        int_pend_s;
  logic        exc_pend_s;
  logic [4:0]  code_s;
  logic        bd_cap_s;
  logic [31:0] epc_cap_s;

  assign exl_s      = (state_r == HANDLER);
  assign int_pend_s = (|(hw_int & im_r)) & ie_r & ~exl_s;
  assign exc_pend_s = (exc_code_in != 5'd0) & ~exl_s;
  assign int_req    = int_pend_s | exc_pend_s;
  assign code_s     = int_pend_s ? 5'd0 : exc_code_in;

`ifdef CP0_BD_EN
  // pc-4 leaves bits [1:0] intact, so misaligned AdEL/AdES addresses survive.
  assign bd_cap_s  = bd;
  assign epc_cap_s = bd ? (pc - 32'd4) : pc;
`else
  logic bd_unused_s;
  assign bd_unused_s = bd;
  assign bd_cap_s    = 1'b0;
  assign epc_cap_s   = pc;
`endif

  // State register with asynchronous reset; IP samples the raw lines every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= USER;
      im_r       <= 6'd0;
      ie_r       <= 1'b0;
      ip_r       <= 6'd0;
      exc_code_r <= 5'd0;
      bd_r       <= 1'b0;
      epc_r      <= 32'd0;
    end else begin
      state_r    <= state_n_s;
      im_r       <= im_n_s;
      ie_r       <= ie_n_s;
      ip_r       <= hw_int;
      exc_code_r <= exc_code_n_s;
      bd_r       <= bd_n_s;
      epc_r      <= epc_n_s;
    end
  end

  // Next state: handler entry drops any mtc0; eret forces EXL low even over an SR write.
  always_comb begin
    state_n_s    = state_r;
    im_n_s       = im_r;
    ie_n_s       = ie_r;
    exc_code_n_s = exc_code_r;
    bd_n_s       = bd_r;
    epc_n_s      = epc_r;
    if (int_req) begin
      state_n_s    = HANDLER;
      exc_code_n_s = code_s;
      bd_n_s       = bd_cap_s;
      epc_n_s      = epc_cap_s;
    end else begin
      if (we && (a2 == 5'd12)) begin
        im_n_s    = din[15:10];
        ie_n_s    = din[0];
        state_n_s = din[1] ? HANDLER : USER;
      end else if (we && (a2 == 5'd14)) begin
        epc_n_s = din;
      end else begin
        epc_n_s = epc_r;
      end
      if (eret) begin
        state_n_s = USER;
      end else begin
        exc_code_n_s = exc_code_r;
      end
    end
  end

  // mfc0 read mux straight from register state (no write bypass).
  always_comb begin
    dout = 32'd0;
    case (a1)
      5'd12:   dout = {16'd0, im_r, 8'd0, exl_s, ie_r};
      5'd13:   dout = {bd_r, 15'd0, ip_r, 3'd0, exc_code_r, 2'd0};
      5'd14:   dout = epc_r;
      5'd15:   dout = PRID_VAL;
      default: dout = 32'd0;
    endcase
  end

  assign epc_out = epc_r;

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0; handles both CP0_BD_EN builds.
module tb_cp0;
  logic        clk;
  logic        reset;
  logic [4:0]  a1, a2;
  logic [31:0] din;
  logic        we;
  logic [31:0] pc;
  logic        bd;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        eret;
  logic [31:0] dout, epc_out;
  logic        int_req;

  int checks_r;
  int errors_r;

  localparam logic [31:0] PRID = 32'h0019_0007;

  cp0 dut (
    .clk(clk), .reset(reset), .a1(a1), .a2(a2), .din(din), .we(we),
    .pc(pc), .bd(bd), .exc_code_in(exc_code_in), .hw_int(hw_int),
    .eret(eret), .dout(dout), .epc_out(epc_out), .int_req(int_req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r = checks_r + 1;
    if (got !== exp) begin
      errors_r = errors_r + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    a1 = r;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic chk_req(input string tag, input logic exp);
    #1;
    check(tag, {31'd0, int_req}, {31'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks_r = 0; errors_r = 0;
    reset = 1'b1; a1 = 5'd0; a2 = 5'd0; din = 32'd0; we = 1'b0;
    pc = 32'd0; bd = 1'b0; exc_code_in = 5'd0; hw_int = 6'd0; eret = 1'b0;
    #12 reset = 1'b0;
    chk_req("rst_int_req", 1'b0);
    check("rst_epc_out", epc_out, 32'd0);
    chk_reg("rst_sr", 5'd12, 32'd0);
    chk_reg("rst_cause", 5'd13, 32'd0);
    chk_reg("rst_prid", 5'd15, PRID);
    step();

    // Overflow exception
    exc_code_in = 5'd12; pc = 32'h0000_3010; bd = 1'b0;
    chk_req("ov_req", 1'b1);
    step();
    exc_code_in = 5'd0;
    chk_req("ov_req_after", 1'b0);
    chk_reg("ov_cause", 5'd13, 32'h0000_0030);
    check("ov_epc", epc_out, 32'h0000_3010);
    chk_reg("ov_sr", 5'd12, 32'h0000_0002);

    // Masked while in handler; IP still tracks the lines
    exc_code_in = 5'd12; hw_int = 6'h3F;
    chk_req("hdl_mask", 1'b0);
    step();
    chk_reg("hdl_ip", 5'd13, 32'h0000_FC30);
    chk_req("hdl_mask2", 1'b0);

    // SR write inside handler keeps EXL=1, IE=1, IM=0
    exc_code_in = 5'd0; hw_int = 6'd1; we = 1'b1; a2 = 5'd12; din = 32'h0000_0003;
    step();
    we = 1'b0;
    chk_reg("hdl_sr_wr", 5'd12, 32'h0000_0003);

    // eret together with SR write: IM/IE apply, EXL cleared; interrupt beats exception
    eret = 1'b1; we = 1'b1; a2 = 5'd12; din = 32'h0000_0403;
    exc_code_in = 5'd5; pc = 32'h0000_3100;
    chk_req("eret_cycle_req", 1'b0);
    step();
    eret = 1'b0; we = 1'b0;
    chk_reg("eret_sr", 5'd12, 32'h0000_0401);
    chk_req("int_fires", 1'b1);
    step();
    chk_reg("int_cause", 5'd13, 32'h0000_0400);
    check("int_epc", epc_out, 32'h0000_3100);
    chk_req("int_one_cycle", 1'b0);

    // IM=0: only the exception fires
    eret = 1'b1; we = 1'b1; a2 = 5'd12; din = 32'h0000_0001; pc = 32'h0000_3200;
    step();
    eret = 1'b0; we = 1'b0;
    chk_reg("im0_sr", 5'd12, 32'h0000_0001);
    chk_req("im0_req", 1'b1);
    step();
    chk_reg("im0_cause", 5'd13, 32'h0000_0414);
    check("im0_epc", epc_out, 32'h0000_3200);

    // Collision: entry wins over EPC write
    eret = 1'b1; exc_code_in = 5'd0; hw_int = 6'd0;
    step();
    eret = 1'b0;
    chk_req("coll_idle", 1'b0);
    exc_code_in = 5'd12; pc = 32'h0000_3000; we = 1'b1; a2 = 5'd14; din = 32'hDEAD_BEEF;
    step();
    we = 1'b0; exc_code_in = 5'd0;
    check("coll_epc", epc_out, 32'h0000_3000);
    eret = 1'b1;
    step();
    eret = 1'b0;
    we = 1'b1; a2 = 5'd14; din = 32'hDEAD_BEEF;
    chk_reg("no_bypass", 5'd14, 32'h0000_3000);
    step();
    we = 1'b0;
    chk_reg("epc_wr", 5'd14, 32'hDEAD_BEEF);
    chk_req("epc_wr_req", 1'b0);

    // Delay-slot AdEL
    exc_code_in = 5'd4; pc = 32'h0000_3022; bd = 1'b1;
    step();
    exc_code_in = 5'd0; bd = 1'b0;
`ifdef CP0_BD_EN
    check("ds_epc", epc_out, 32'h0000_301E);
    chk_reg("ds_cause", 5'd13, 32'h8000_0010);
`else
    check("ds_epc", epc_out, 32'h0000_3022);
    chk_reg("ds_cause", 5'd13, 32'h0000_0010);
`endif
    chk_reg("ds_sr", 5'd12, 32'h0000_0003);

    // Async reset mid-handler, between clock edges
    #1 reset = 1'b1;
    chk_reg("ar_sr", 5'd12, 32'd0);
    chk_reg("ar_cause", 5'd13, 32'd0);
    chk_reg("ar_epc", 5'd14, 32'd0);
    check("ar_epc_out", epc_out, 32'd0);
    chk_req("ar_req", 1'b0);
    chk_reg("ar_prid", 5'd15, PRID);
    reset = 1'b0;
    step();
    chk_reg("post_rst_sr", 5'd12, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
    $finish;
  end
endmodule
